// File: rtl/conv_relu_pool.sv
// Post-accumulation stage: streams a finished FP32 map from the accumulator SRAM,
// applies optional ReLU and 2x2/stride-2 max pooling, writes the pooled map row-major.
module conv_relu_pool #(
    parameter int DataWidth   = 32,
    parameter int MaxRowWidth = 9,
    parameter int MaxColWidth = 9,
    parameter int AddrWidth   = 18
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [MaxRowWidth-1:0] row_in,
    input  logic [MaxColWidth-1:0] col_in,
    input  logic                   relu_en,
    output logic                   busy,
    output logic                   done,
    output logic [AddrWidth-1:0]   rd_addr,
    output logic                   rd_en,
    input  logic [DataWidth-1:0]   rd_data,
    output logic [AddrWidth-1:0]   wr_addr,
    output logic [DataWidth-1:0]   wr_data,
    output logic                   wr_en
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [AddrWidth-1:0]   AOne = AddrWidth'(1);
    localparam logic [AddrWidth-1:0]   ATwo = AddrWidth'(2);
    localparam logic [MaxRowWidth-1:0] ROne = MaxRowWidth'(1);
    localparam logic [MaxColWidth-1:0] COne = MaxColWidth'(1);

    state_t                 state;
    logic [AddrWidth-1:0]   col_w;
    logic [AddrWidth-1:0]   col2_w;
    logic [MaxRowWidth-1:0] or_last;
    logic [MaxColWidth-1:0] oc_last;
    logic [MaxRowWidth-1:0] orow;
    logic [MaxColWidth-1:0] ocol;
    logic [1:0]             phase;
    logic [AddrWidth-1:0]   base;
    logic [AddrWidth-1:0]   row_base;
    logic                   relu;
    logic                   dvld;
    logic [1:0]             dph;
    logic [DataWidth-1:0]   mx;
    logic [DataWidth-1:0]   cand;
    logic [DataWidth-1:0]   pooled;

    // Sign-magnitude ordering on raw bits; +0 beats -0 through the sign rule.
    function automatic logic [DataWidth-1:0] fp_max(input logic [DataWidth-1:0] a,
                                                     input logic [DataWidth-1:0] b);
        if (a[DataWidth-1] != b[DataWidth-1])
            return a[DataWidth-1] ? b : a;
        else if (!a[DataWidth-1])
            return (a[DataWidth-2:0] >= b[DataWidth-2:0]) ? a : b;
        else
            return (a[DataWidth-2:0] <= b[DataWidth-2:0]) ? a : b;
    endfunction

    always_comb begin
        cand   = (dph == 2'd0) ? rd_data : fp_max(mx, rd_data);
        pooled = (relu && cand[DataWidth-1]) ? '0 : cand;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            col_w    <= '0;
            col2_w   <= '0;
            or_last  <= '0;
            oc_last  <= '0;
            orow     <= '0;
            ocol     <= '0;
            phase    <= '0;
            base     <= '0;
            row_base <= '0;
            relu     <= 1'b0;
            dvld     <= 1'b0;
            dph      <= '0;
            mx       <= '0;
        end else begin
            // Read-return tracking: data for the read shown this cycle lands next cycle.
            dvld  <= rd_en;
            dph   <= phase;
            wr_en <= 1'b0;
            if (dvld) begin
                mx <= cand;
                if (dph == 2'd3) begin
                    wr_en   <= 1'b1;
                    wr_data <= pooled;
                end
            end
            if (wr_en)
                wr_addr <= wr_addr + AOne;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        relu     <= relu_en;
                        col_w    <= AddrWidth'(col_in);
                        col2_w   <= AddrWidth'(col_in) << 1;
                        or_last  <= (row_in >> 1) - ROne;
                        oc_last  <= (col_in >> 1) - COne;
                        orow     <= '0;
                        ocol     <= '0;
                        phase    <= '0;
                        base     <= '0;
                        row_base <= '0;
                        rd_addr  <= '0;
                        wr_addr  <= '0;
                        if (row_in < MaxRowWidth'(2) || col_in < MaxColWidth'(2)) begin
                            state <= FIN;
                        end else begin
                            rd_en <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    phase <= phase + 2'd1;
                    case (phase)
                        2'd0: rd_addr <= base + AOne;
                        2'd1: rd_addr <= base + col_w;
                        2'd2: rd_addr <= base + col_w + AOne;
                        default: begin
                            if (ocol == oc_last && orow == or_last) begin
                                rd_en <= 1'b0;
                                state <= DRAIN;
                            end else if (ocol == oc_last) begin
                                ocol     <= '0;
                                orow     <= orow + ROne;
                                row_base <= row_base + col2_w;
                                base     <= row_base + col2_w;
                                rd_addr  <= row_base + col2_w;
                            end else begin
                                ocol    <= ocol + COne;
                                base    <= base + ATwo;
                                rd_addr <= base + ATwo;
                            end
                        end
                    endcase
                end
                DRAIN: begin
                    // Only the final window's write can appear once reads have stopped.
                    if (wr_en) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                default: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/conv_relu_pool.md
Name: conv_relu_pool

Overview:
- Post-accumulation stage that runs once the convolution/accumulate stage has finished all input-channel groups for one output channel.
- Reads the finished FP32 feature map from the accumulator SRAM, applies optional ReLU, and performs 2x2/stride-2 max pooling.
- Writes the pooled map to an output SRAM in row-major order starting at address 0.
- Issues one read per cycle and produces one write per 4 cycles.

Parameters:
DataWidth, 32, IEEE-754 single-precision word width
MaxRowWidth, 9, width of row dimension input
MaxColWidth, 9, width of column dimension input
AddrWidth, 18, SRAM address width (read and write side)

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a pass (ignored when busy=1)
row_in  in  MaxRowWidth  feature-map rows R; sampled on accepted start
col_in  in  MaxColWidth  feature-map columns C; sampled on accepted start
relu_en  in  1  1 = apply ReLU; sampled on accepted start
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse at end of pass
rd_addr  out  AddrWidth  accumulator SRAM read address
rd_en  out  1  read strobe
rd_data  in  DataWidth  read data, valid exactly 1 cycle after rd_en
wr_addr  out  AddrWidth  output SRAM write address
wr_data  out  DataWidth  pooled result
wr_en  out  1  write strobe

Behaviour:
- Interface: one clock Clk; reset Rst is synchronous and active-high.
- Reset, or Rst asserted mid-pass: FSM goes to IDLE. All outputs become 0 (busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data) and all counters clear. Any partial pass is abandoned with no further writes.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: start=1 latches R, C and relu_en, then moves to RUN.
  - If R<2 or C<2, go IDLE -> FIN instead: no reads, no writes.
- Output dimensions: OR = floor(R/2), OC = floor(C/2). An odd last row or column is never read.
- RUN, address generation:
  - Window base b = 2*orow*C + 2*ocol, held in an incremental register (no multiplier).
  - Per window, issue rd_en=1 on four consecutive cycles with rd_addr = b, b+1, b+C, b+C+1.
  - After each window, b += 2 for the next column. At the end of an output row, b = row_base + 2*C, where row_base is the base of the current output row.
  - After the last read of window (OR-1, OC-1), go to DRAIN.
- Compare path: a running max register. The first datum of a window loads it; the next three are compared against it.
- FP max rule:
  - Signs differ: the sign=0 operand wins.
  - Both sign=0: larger bits[30:0] wins.
  - Both sign=1: smaller bits[30:0] wins.
  - Equal: either (identical value). +0 vs -0 gives +0.
  - NaN/Inf are not special-cased.
- ReLU: applied to the window max. If relu_en=1 and sign=1, the result is 32'h0.
- Write timing:
  - Read k of a window issued at cycle t gives data at t+1.
  - The 4th datum arrives at t4+1; wr_en=1 at t4+2 with the final result.
  - wr_addr starts at 0 and increments by 1 per write.
  - wr_data holds its value when wr_en=0.
- DRAIN: wait until the last write has been issued, then go to FIN.
- FIN: done=1 for one cycle, busy drops in the following cycle, return to IDLE.
- Totals: OR*OC writes; 4*OR*OC reads.
- Latency: first rd_en one cycle after start; first wr_en at cycle 6 after start; done one cycle after the last wr_en.
- start during busy is ignored. start in the same cycle as Rst is ignored.

Test Plan:
- R=C=4, relu_en=0, map value(r,c)=float(r*4+c) -> wr_addr 0..3 get 5.0, 7.0, 13.0, 15.0. Read addresses in order 0, 1, 4, 5, 2, 3, 6, 7, 8, ...; done one cycle after the 4th write.
- R=C=4, all values negative, window 0 = {-1.0, -3.0, -0.5, -2.0}: relu_en=0 -> word 0 = -0.5; relu_en=1 -> all 4 words = 32'h0.
- R=5, C=7 -> exactly 6 writes (OR=2, OC=3); no rd_addr ever in row 4 or column 6.
- R=1, C=8 -> zero rd_en, zero wr_en; done at cycle 2 after start.
- Rst pulsed after 3 writes of a 4x8 pass -> outputs 0 next cycle, no further writes. A new start then restarts with wr_addr=0 and rd_addr=0.
- start re-pulsed mid-pass -> no effect on addresses or counts. Window {+0.0, -0.0, -0.0, -0.0} with relu_en=0 -> 32'h00000000.
